// File: rtl/video_timing_pkg.sv
// Shared types and standard raster mode constants for the video timing generator.
// Pure declarations: no latency, no backpressure.
package video_timing_pkg;

    localparam int CNT_W_DEF = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_mode_t;

    localparam axis_mode_t H_1080P = '{active: 16'd1920, fp: 16'd88,  sync: 16'd44,  bp: 16'd148};
    localparam axis_mode_t V_1080P = '{active: 16'd1080, fp: 16'd4,   sync: 16'd5,   bp: 16'd36};
    localparam axis_mode_t H_720P  = '{active: 16'd1280, fp: 16'd110, sync: 16'd40,  bp: 16'd220};
    localparam axis_mode_t V_720P  = '{active: 16'd720,  fp: 16'd5,   sync: 16'd5,   bp: 16'd20};
    localparam axis_mode_t H_XGA   = '{active: 16'd1024, fp: 16'd24,  sync: 16'd136, bp: 16'd160};
    localparam axis_mode_t V_XGA   = '{active: 16'd768,  fp: 16'd3,   sync: 16'd6,   bp: 16'd29};
    localparam axis_mode_t H_SVGA  = '{active: 16'd800,  fp: 16'd40,  sync: 16'd128, bp: 16'd88};
    localparam axis_mode_t V_SVGA  = '{active: 16'd600,  fp: 16'd1,   sync: 16'd4,   bp: 16'd23};
    localparam axis_mode_t H_VGA   = '{active: 16'd640,  fp: 16'd16,  sync: 16'd96,  bp: 16'd48};
    localparam axis_mode_t V_VGA   = '{active: 16'd480,  fp: 16'd10,  sync: 16'd2,   bp: 16'd33};

    function automatic int axis_total(input axis_mode_t m);
        return int'(m.active) + int'(m.fp) + int'(m.sync) + int'(m.bp);
    endfunction

endpackage

// File: rtl/video_timing_axis_cnt.sv
// One raster axis: segment counter (sync, back porch, active, front porch) with decoded flags.
// Flags are combinational from the count register; advances only when i_adv, no backpressure.
module video_timing_axis_cnt #(
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_sync,
    input  logic [CNT_W-1:0] i_bp,
    input  logic [CNT_W-1:0] i_active,
    input  logic [CNT_W-1:0] i_fp,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_sync,
    output logic             o_active,
    output logic             o_wrap
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] act_start;
    logic [CNT_W-1:0] act_end;
    logic [CNT_W-1:0] total_m1;

    assign act_start = i_sync + i_bp;
    assign act_end   = act_start + i_active;
    assign total_m1  = act_end + i_fp - ONE;

    assign o_sync   = (o_cnt < i_sync);
    assign o_active = (o_cnt >= act_start) && (o_cnt < act_end);
    assign o_wrap   = (o_cnt == total_m1);
    assign o_idx    = o_cnt - act_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_adv) begin
            o_cnt <= o_wrap ? '0 : o_cnt + ONE;
        end
    end

endmodule

// File: rtl/video_timing_gen_cfg.sv
// Run-time configurable video timing generator: HS/VS/DE, pixel positions, lead-adjustable pixel request.
// All outputs registered one cycle after their counter state; no backpressure, config applied at frame boundaries.
module video_timing_gen_cfg
    import video_timing_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int REQ_LEAD     = 1,
    parameter int DEF_H_ACTIVE = int'(H_720P.active),
    parameter int DEF_H_FP     = int'(H_720P.fp),
    parameter int DEF_H_SYNC   = int'(H_720P.sync),
    parameter int DEF_H_BP     = int'(H_720P.bp),
    parameter int DEF_V_ACTIVE = int'(V_720P.active),
    parameter int DEF_V_FP     = int'(V_720P.fp),
    parameter int DEF_V_SYNC   = int'(V_720P.sync),
    parameter int DEF_V_BP     = int'(V_720P.bp),
    parameter bit DEF_HS_POL   = 1'b1,
    parameter bit DEF_VS_POL   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cfg_h_active,
    input  logic [CNT_W-1:0] i_cfg_h_fp,
    input  logic [CNT_W-1:0] i_cfg_h_sync,
    input  logic [CNT_W-1:0] i_cfg_h_bp,
    input  logic [CNT_W-1:0] i_cfg_v_active,
    input  logic [CNT_W-1:0] i_cfg_v_fp,
    input  logic [CNT_W-1:0] i_cfg_v_sync,
    input  logic [CNT_W-1:0] i_cfg_v_bp,
    input  logic             i_cfg_hs_pol,
    input  logic             i_cfg_vs_pol,
    input  logic             i_cfg_valid,
    output logic             o_cfg_pending,
    output logic             o_cfg_err,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_data_req,
    output logic [CNT_W-1:0] o_x_pos,
    output logic [CNT_W-1:0] o_y_pos,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic [15:0]      o_frame_cnt,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_active
);
    typedef struct packed {
        logic [CNT_W-1:0] h_active, h_fp, h_sync, h_bp;
        logic [CNT_W-1:0] v_active, v_fp, v_sync, v_bp;
        logic             hs_pol, vs_pol;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{
        h_active: CNT_W'(DEF_H_ACTIVE), h_fp: CNT_W'(DEF_H_FP),
        h_sync:   CNT_W'(DEF_H_SYNC),   h_bp: CNT_W'(DEF_H_BP),
        v_active: CNT_W'(DEF_V_ACTIVE), v_fp: CNT_W'(DEF_V_FP),
        v_sync:   CNT_W'(DEF_V_SYNC),   v_bp: CNT_W'(DEF_V_BP),
        hs_pol:   DEF_HS_POL,           vs_pol: DEF_VS_POL
    };
    localparam logic [CNT_W-1:0] LEAD = CNT_W'(REQ_LEAD);

    state_t           state;
    cfg_t             cur, shadow, req_cfg;
    logic [CNT_W+1:0] h_tot_req, v_tot_req;
    logic             cfg_ok, run, frame_end, apply;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_idx, v_idx, hsb, req_lo, req_hi;
    logic             h_sync, v_sync, h_act, v_act, h_wrap, v_wrap, h_req;

    assign req_cfg = '{i_cfg_h_active, i_cfg_h_fp, i_cfg_h_sync, i_cfg_h_bp,
                       i_cfg_v_active, i_cfg_v_fp, i_cfg_v_sync, i_cfg_v_bp,
                       i_cfg_hs_pol, i_cfg_vs_pol};

    // Totals are summed two bits wider so an overflowing request is detectable.
    assign h_tot_req = (CNT_W+2)'(i_cfg_h_active) + (CNT_W+2)'(i_cfg_h_fp)
                     + (CNT_W+2)'(i_cfg_h_sync) + (CNT_W+2)'(i_cfg_h_bp);
    assign v_tot_req = (CNT_W+2)'(i_cfg_v_active) + (CNT_W+2)'(i_cfg_v_fp)
                     + (CNT_W+2)'(i_cfg_v_sync) + (CNT_W+2)'(i_cfg_v_bp);
    assign cfg_ok = (|i_cfg_h_active) && (|i_cfg_h_sync) && (|i_cfg_v_active) && (|i_cfg_v_sync)
                 && (h_tot_req[CNT_W+1:CNT_W] == 2'b00) && (v_tot_req[CNT_W+1:CNT_W] == 2'b00);

    assign run       = (state == ST_RUN);
    assign frame_end = run && h_wrap && v_wrap;
    assign apply     = o_cfg_pending && (!run || frame_end);

    // Request window is the active window shifted earlier; the lead never exceeds sync+bp.
    assign hsb    = cur.h_sync + cur.h_bp;
    assign req_lo = hsb - LEAD;
    assign req_hi = hsb + cur.h_active - LEAD;
    assign h_req  = (h_cnt >= req_lo) && (h_cnt < req_hi);

    assign o_h_active = cur.h_active;
    assign o_v_active = cur.v_active;

    video_timing_axis_cnt #(.CNT_W(CNT_W)) u_h_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(!run), .i_adv(1'b1),
        .i_sync(cur.h_sync), .i_bp(cur.h_bp), .i_active(cur.h_active), .i_fp(cur.h_fp),
        .o_cnt(h_cnt), .o_idx(h_idx), .o_sync(h_sync), .o_active(h_act), .o_wrap(h_wrap)
    );

    video_timing_axis_cnt #(.CNT_W(CNT_W)) u_v_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(!run), .i_adv(h_wrap),
        .i_sync(cur.v_sync), .i_bp(cur.v_bp), .i_active(cur.v_active), .i_fp(cur.v_fp),
        .o_cnt(v_cnt), .o_idx(v_idx), .o_sync(v_sync), .o_active(v_act), .o_wrap(v_wrap)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cur           <= DEF_CFG;
            shadow        <= DEF_CFG;
            o_cfg_pending <= 1'b0;
            o_cfg_err     <= 1'b0;
            o_hs          <= ~DEF_HS_POL;
            o_vs          <= ~DEF_VS_POL;
            o_de          <= 1'b0;
            o_data_req    <= 1'b0;
            o_x_pos       <= '0;
            o_y_pos       <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 16'd0;
        end else begin
            o_cfg_err <= i_cfg_valid && !cfg_ok;
            if (apply) cur <= shadow;
            // A strobe on the apply cycle wins: old shadow goes live, new one waits.
            if (i_cfg_valid && cfg_ok) begin
                shadow        <= req_cfg;
                o_cfg_pending <= 1'b1;
            end else if (apply) begin
                o_cfg_pending <= 1'b0;
            end
            if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;

            case (state)
                ST_IDLE: if (i_en) state <= ST_RUN;
                ST_RUN:  if (frame_end && !i_en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            o_hs          <= (run && h_sync) ? cur.hs_pol : ~cur.hs_pol;
            o_vs          <= (run && v_sync) ? cur.vs_pol : ~cur.vs_pol;
            o_de          <= run && h_act && v_act;
            o_data_req    <= run && h_req && v_act;
            o_x_pos       <= (run && h_act && v_act) ? h_idx : '0;
            o_y_pos       <= (run && v_act) ? v_idx : '0;
            o_line_start  <= run && (h_cnt == '0);
            o_frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule
